i2c_sub_ctrl: RTL and testbench

//  Byte-level sequencer of the I2C subordinate interface. Consumes start/stop levels from the

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_sync_edge.sv | 38 +++
 rtl/i2c_sub_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_sub_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Package for the I2C subordinate controller.
// Holds the byte-sequencer state encoding, the byte width and the ACK/NACK
// bus levels shared by the RTL and its bench.
package i2c_pkg;

  localparam int   I2C_BYTE_W = 8;
  localparam logic ACK        = 1'b0;  // receiver pulls sda low
  localparam logic NACK       = 1'b1;  // receiver leaves sda released

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    DEV_ACK,
    REGPTR,
    PTR_ACK,
    WRITE,
    WR_ACK,
    READ,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// N-stage synchronizer with one-clk rise/fall pulses.
// Ports:
//   clk, rst    system clock, synchronous active-low reset
//   din         asynchronous input level
//   dout        synchronized level
//   rise, fall  one-clk pulses on a 0->1 / 1->0 change of dout
// RST_VAL lets idle-high bus lines (scl/sda) come out of reset at their idle
// level so no false edge is produced when reset is released.
module i2c_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/i2c_sub_ctrl.sv
// Byte-level sequencer of the I2C subordinate interface.
// Ports:
//   clk, rst    system clock (>= 8x scl), synchronous active-low reset
//   scl, sda    raw bus clock/data
//   start, stop level flags from the start/stop detector (asynchronous)
//   sda_oe      1 = pull sda low (ACK or read data 0)
//   reg_addr    register pointer
//   wr_data     write byte, valid while wr_en
//   wr_en       one-clk write strobe
//   rd_req      one-clk read request for reg_addr
//   rd_data     register contents, sampled one clk after rd_req
//   busy        1 while a matched transfer is in progress
//   state_dbg   current sequencer state
// Register-file handshake: wr_en and rd_req are single-cycle strobes with no
// back-pressure. wr_data/reg_addr are stable while wr_en is high and the
// pointer advances on the following clk. rd_data must be valid on the clk
// edge that ends the cycle after rd_req.
import i2c_pkg::*;

module i2c_sub_ctrl #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  input  logic       start,
  input  logic       stop,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output state_t     state_dbg
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_s, start_evt, start_fall;
  logic stop_s, stop_evt, stop_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
    .clk(clk), .rst(rst), .din(scl), .dout(scl_s), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
    .clk(clk), .rst(rst), .din(sda), .dout(sda_s), .rise(sda_rise), .fall(sda_fall));
  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_start (
    .clk(clk), .rst(rst), .din(start), .dout(start_s), .rise(start_evt), .fall(start_fall));
  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_stop (
    .clk(clk), .rst(rst), .din(stop), .dout(stop_s), .rise(stop_evt), .fall(stop_fall));

  state_t                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
  logic [7:0]              reg_addr_q, reg_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_req_q, rd_req_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    busy_q, busy_d;
  // ACK slots: 0 = waiting for the fall that starts driving, 1 = driving.
  // RD_ACK: 1 = controller ACK seen, next fall fetches the next byte.
  logic                    phase_q, phase_d;
  // High the clk after rd_req: rd_data is captured and its MSB driven.
  logic                    load_q, load_d;
  logic [I2C_BYTE_W-1:0]   byte_in;

  assign byte_in = {shift_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_req_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      phase_q    <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_req_q   <= rd_req_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      phase_q    <= phase_d;
      load_q     <= load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_req_d   = 1'b0;
    sda_oe_d   = sda_oe_q;
    phase_d    = phase_q;
    load_d     = 1'b0;

    // Pointer advances the clk after each write strobe (8-bit wrap).
    if (wr_en_q) reg_addr_d = reg_addr_q + 8'd1;

    if (stop_evt) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (start_evt) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        DEVADDR, REGPTR, WRITE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == DEVADDR) begin
                state_d = (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE;
              end else if (state_q == REGPTR) begin
                reg_addr_d = byte_in;
                state_d    = PTR_ACK;
              end else begin
                wr_data_d = byte_in;
                wr_en_d   = 1'b1;
                state_d   = WR_ACK;
              end
            end
          end
        end
        DEV_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              if (state_q == DEV_ACK && shift_q[0]) begin
                rd_req_d = 1'b1;
                load_d   = 1'b1;
                state_d  = READ;
              end else if (state_q == DEV_ACK) begin
                state_d = REGPTR;
              end else begin
                state_d = WRITE;
              end
            end
          end
        end
        READ: begin
          // The first bit is driven on the load clk rather than on the
          // releasing scl fall, because rd_data only arrives then.
          if (load_q) begin
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_fall && !phase_q) begin
            sda_oe_d = 1'b0;
          end else if (scl_fall) begin
            rd_req_d = 1'b1;
            load_d   = 1'b1;
            phase_d  = 1'b0;
            state_d  = READ;
          end else if (scl_rise) begin
            if (sda_s == ACK) begin
              reg_addr_d = reg_addr_q + 8'd1;
              phase_d    = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end

    busy_d = !(state_d == IDLE || state_d == DEVADDR || state_d == IGNORE);
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign rd_req    = rd_req_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, scl_s, sda_rise, sda_fall, start_s, start_fall,
                       stop_s, stop_fall, shift_q[7]};

endmodule

// File: tb/tb_i2c_sub_ctrl.sv
// Bench for i2c_sub_ctrl: a bus-controller model drives scl/sda/start/stop,
// a transaction-level model predicts register writes, read requests, ACKs
// and read data; a monitor pops expected strobes as the DUT presents them.
module tb_i2c_sub_ctrl;
  import i2c_pkg::*;

  localparam int         Q   = 5;       // clks per quarter scl period
  localparam logic [6:0] DEV = 7'h42;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       sda_bus;
  logic       sda_oe, wr_en, rd_req, busy;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'h00;
  state_t     state_dbg;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_sub_ctrl #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus), .start(start), .stop(stop),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_data(rd_data), .busy(busy), .state_dbg(state_dbg));

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_wr_q[$];   // {reg_addr, wr_data}
  logic [7:0]  exp_rd_q[$];   // reg_addr at rd_req
  logic [7:0]  regs[256];     // bench register file (updated by wr_en)
  logic [7:0]  mem[256];      // reference model contents
  logic [7:0]  m_ptr = 8'h00; // reference model pointer
  logic [7:0]  wbuf[$];
  int          oe_cycles = 0;
  int          busy_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (sda_oe) oe_cycles++;
      if (busy) busy_cycles++;
      if (wr_en) begin
        regs[reg_addr] = wr_data;
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: got %0h expected none", {reg_addr, wr_data});
        end else begin
          check("wr_strobe", {16'h0, reg_addr, wr_data}, {16'h0, exp_wr_q.pop_front()});
        end
      end
      if (rd_req) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got %0h expected none", reg_addr);
        end else begin
          check("rd_req_addr", {24'h0, reg_addr}, {24'h0, exp_rd_q.pop_front()});
        end
      end
    end
  end

  // Register file read port: data only valid the cycle after rd_req.
  always @(negedge clk) begin
    if (rd_req) rd_data = regs[reg_addr];
    else        rd_data = 8'($urandom);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic put_bit(input logic b, output logic smp);
    wait_q(); m_sda = b;
    wait_q(); scl = 1'b1;
    wait_q(); smp = sda_bus;
    wait_q(); scl = 1'b0;
  endtask

  task automatic m_start();
    if (!scl) begin
      wait_q(); m_sda = 1'b1;
      wait_q(); scl = 1'b1;
    end
    wait_q(); m_sda = 1'b0; start = 1'b1;
    wait_q(); start = 1'b0;
    wait_q(); scl = 1'b0;
  endtask

  task automatic m_stop();
    wait_q(); m_sda = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); m_sda = 1'b1; stop = 1'b1;
    wait_q(); stop = 1'b0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    put_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      b[i] = s;
    end
    put_bit(mack, s);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    regs[a] = v;
    mem[a]  = v;
  endtask

  task automatic check_idle(input string name);
    repeat (4) @(negedge clk);
    check(name, {26'h0, busy, sda_oe, state_dbg}, {26'h0, 2'b00, IDLE});
    check("reg_addr", {24'h0, reg_addr}, {24'h0, m_ptr});
  endtask

  // Write transaction: data bytes taken from wbuf.
  task automatic wr_txn(input logic [6:0] a, input logic [7:0] p);
    logic ack;
    logic hit;
    int   oe0, busy0;
    hit   = (a == DEV);
    oe0   = oe_cycles;
    busy0 = busy_cycles;
    m_start();
    send_byte({a, 1'b0}, ack);
    check("addr_ack", {31'h0, ack}, {31'h0, hit ? ACK : NACK});
    check("busy_after_addr", {31'h0, busy}, {31'h0, hit});
    send_byte(p, ack);
    check("ptr_ack", {31'h0, ack}, {31'h0, hit ? ACK : NACK});
    if (hit) m_ptr = p;
    foreach (wbuf[i]) begin
      if (hit) begin
        exp_wr_q.push_back({m_ptr, wbuf[i]});
        mem[m_ptr] = wbuf[i];
        m_ptr = m_ptr + 8'd1;
      end
      send_byte(wbuf[i], ack);
      check("data_ack", {31'h0, ack}, {31'h0, hit ? ACK : NACK});
    end
    m_stop();
    check_idle("idle_after_write");
    if (!hit) begin
      check("quiet_sda_oe", oe_cycles - oe0, 0);
      check("quiet_busy", busy_cycles - busy0, 0);
    end
    wbuf.delete();
  endtask

  // Pointer write, repeated start, then n reads (ACK all but the last).
  task automatic rd_txn(input logic [7:0] p, input int n);
    logic       ack;
    logic       last;
    logic [7:0] d;
    m_start();
    send_byte({DEV, 1'b0}, ack);
    check("rd_addr_w_ack", {31'h0, ack}, {31'h0, ACK});
    send_byte(p, ack);
    check("rd_ptr_ack", {31'h0, ack}, {31'h0, ACK});
    m_ptr = p;
    m_start();
    exp_rd_q.push_back(m_ptr);
    send_byte({DEV, 1'b1}, ack);
    check("rd_addr_r_ack", {31'h0, ack}, {31'h0, ACK});
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      if (!last) exp_rd_q.push_back(m_ptr + 8'd1);
      read_byte(last ? NACK : ACK, d);
      check("rd_data", {24'h0, d}, {24'h0, mem[m_ptr]});
      if (!last) m_ptr = m_ptr + 8'd1;
    end
    check("ignore_after_nack", {28'h0, state_dbg}, {28'h0, IGNORE});
    m_stop();
    check_idle("idle_after_read");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s;
    logic       ack;
    logic [6:0] a;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      preload(8'(i), v);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'h0, sda_oe, wr_en, rd_req, busy}, 32'h0);
    check("reset_regs", {16'h0, reg_addr, wr_data}, 32'h0);
    check("reset_state", {28'h0, state_dbg}, {28'h0, IDLE});
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 1: write two bytes at 0x10
    wbuf = '{8'hA5, 8'h5A};
    wr_txn(DEV, 8'h10);

    // 2: read 0x3C, 0xC3 from 0x11/0x12
    preload(8'h11, 8'h3C);
    preload(8'h12, 8'hC3);
    rd_txn(8'h11, 2);

    // 3: address mismatch (0x86)
    wr_txn(7'h43, 8'h10);

    // 4: stop in the middle of a data byte
    m_start();
    send_byte({DEV, 1'b0}, ack);
    check("mid_addr_ack", {31'h0, ack}, {31'h0, ACK});
    send_byte(8'h10, ack);
    check("mid_ptr_ack", {31'h0, ack}, {31'h0, ACK});
    m_ptr = 8'h10;
    for (int i = 0; i < 4; i++) put_bit(1'($urandom), s);
    m_stop();
    check_idle("idle_after_partial");

    // 5: pointer wrap 0xFF -> 0x00
    wbuf = '{8'h11, 8'h22};
    wr_txn(DEV, 8'hFF);

    // 6: reset in the middle of a read
    m_start();
    send_byte({DEV, 1'b0}, ack);
    send_byte(8'h20, ack);
    m_ptr = 8'h20;
    m_start();
    exp_rd_q.push_back(m_ptr);
    send_byte({DEV, 1'b1}, ack);
    check("rst_rd_addr_ack", {31'h0, ack}, {31'h0, ACK});
    for (int i = 0; i < 3; i++) put_bit(1'b1, s);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midread_reset_outputs", {10'h0, sda_oe, wr_en, rd_req, busy, reg_addr, wr_data},
          32'h0);
    check("midread_reset_state", {28'h0, state_dbg}, {28'h0, IDLE});
    m_ptr = 8'h00;
    m_stop();
    wbuf = '{8'($urandom)};
    wr_txn(DEV, 8'h30);

    // Randomized transactions
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 2) < 2) begin
        a = DEV;
        if ($urandom_range(0, 3) == 0) begin
          a = 7'($urandom);
          if (a == DEV) a = a ^ 7'h01;
        end
        for (int k = 0; k < $urandom_range(1, 3); k++) wbuf.push_back(8'($urandom));
        wr_txn(a, 8'($urandom));
      end else begin
        rd_txn(8'($urandom), $urandom_range(1, 3));
      end
    end

    repeat (20) @(negedge clk);
    check("exp_wr_q_drained", exp_wr_q.size(), 0);
    check("exp_rd_q_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
